// File: rtl/wb_if.sv
// Write-back port bundle: ALU request, load-return handshake and the reg_bank write port.
// The pending vector exists only when WB_SCOREBOARD_EN is defined.
interface wb_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int CW     = 3
) ();
  logic              alu_we;
  logic [AW-1:0]     alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [NREG-1:0]   enable;
  logic [DATA_W-1:0] ldr_data;
  logic [CW-1:0]     fifo_count;
`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0]   pending;
`endif

  // Load handshake: a load transfers on a cycle where ld_valid && ld_ready;
  // the source holds ld_addr/ld_data stable while ld_valid is high and not yet accepted.
  modport master (
    output alu_we, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  ld_ready, enable, ldr_data, fifo_count
`ifdef WB_SCOREBOARD_EN
    , input pending
`endif
  );

  modport slave (
    input  alu_we, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output ld_ready, enable, ldr_data, fifo_count
`ifdef WB_SCOREBOARD_EN
    , output pending
`endif
  );
endinterface

// File: rtl/reg_writeback.sv
// Write-back merge of ALU results and buffered load returns into one registered reg_bank port.
// Optional WB_SCOREBOARD_EN adds a registered per-register pending-load vector.
module reg_writeback #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 16,
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  wb_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [AW-1:0]         addr_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NREG-1:0]       enable_q, enable_d;
  logic [DATA_W-1:0]     ldr_data_q, ldr_data_d;
  logic                  push, pop, not_full;

  assign not_full = (count_q < DEPTH_C);
  assign push     = wb.ld_valid && not_full;
  assign pop      = !wb.alu_we && (count_q != '0);

  always_comb begin
    enable_d   = '0;
    ldr_data_d = ldr_data_q;
    if (wb.alu_we) begin
      enable_d   = NREG'(1) << wb.alu_addr;
      ldr_data_d = wb.alu_data;
    end else if (pop && !kill_q[rd_ptr_q]) begin
      enable_d   = NREG'(1) << addr_q[rd_ptr_q];
      ldr_data_d = data_q[rd_ptr_q];
    end
  end

  // A load pushed in the same cycle as a matching ALU write counts as older, so it is killed too.
  always_comb begin
    kill_d = kill_q;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      if (push && (wr_ptr_q == PW'(j)))
        kill_d[j] = wb.alu_we && (wb.ld_addr == wb.alu_addr);
      else if (wb.alu_we && (addr_q[j] == wb.alu_addr))
        kill_d[j] = 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + (pop  ? PW'(1) : PW'(0));
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      kill_q     <= '0;
      enable_q   <= '0;
      ldr_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      kill_q     <= kill_d;
      enable_q   <= enable_d;
      ldr_data_q <= ldr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= wb.ld_addr;
      data_q[wr_ptr_q] <= wb.ld_data;
    end
  end

  assign wb.ld_ready   = !reset && not_full;
  assign wb.enable     = enable_q;
  assign wb.ldr_data   = ldr_data_q;
  assign wb.fifo_count = count_q;

`ifdef WB_SCOREBOARD_EN
  logic [NREG-1:0] pending_q, pending_d;
  logic [AW-1:0]   addr_nxt [FIFO_DEPTH];
  logic [PW-1:0]   slot;

  // Pending is rebuilt from the post-edge FIFO contents so it lands with the push/pop/kill.
  always_comb begin
    pending_d = '0;
    slot      = '0;
    for (int j = 0; j < FIFO_DEPTH; j++)
      addr_nxt[j] = (push && (wr_ptr_q == PW'(j))) ? wb.ld_addr : addr_q[j];
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      slot = rd_ptr_d + PW'(k);
      if ((CW'(k) < count_d) && !kill_d[slot])
        pending_d[addr_nxt[slot]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign wb.pending = pending_q;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Directed and randomized checks of reg_writeback against a queue-based write-back model.
module tb_reg_writeback;
  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int AW     = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  wb_if #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW), .CW(CW)) wb ();

  reg_writeback #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    bit                killed;
  } ent_t;

  ent_t              mq[$];
  logic [NREG-1:0]   exp_en   = '0;
  logic [DATA_W-1:0] exp_data = '0;
  bit                acc_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p = '0;
    foreach (mq[i]) if (!mq[i].killed) p[mq[i].a] = 1'b1;
    return p;
  endfunction

  // One clock: check ready, advance the model on the current inputs, then check registered outputs.
  task automatic cycle();
    bit   ready, push;
    ent_t e;
    #1;
    ready = !reset && (mq.size() < DEPTH);
    check("ld_ready", 64'(wb.ld_ready), 64'(ready));
    push = wb.ld_valid && ready;
    if (reset) begin
      mq.delete();
      exp_en   = '0;
      exp_data = '0;
      push     = 0;
    end else begin
      exp_en = '0;
      if (wb.alu_we) begin
        foreach (mq[i]) if (mq[i].a == wb.alu_addr) mq[i].killed = 1;
        exp_en   = NREG'(1) << wb.alu_addr;
        exp_data = wb.alu_data;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        if (!e.killed) begin
          exp_en   = NREG'(1) << e.a;
          exp_data = e.d;
        end
      end
      if (push) begin
        e.a = wb.ld_addr;
        e.d = wb.ld_data;
        e.killed = wb.alu_we && (wb.ld_addr == wb.alu_addr);
        mq.push_back(e);
      end
    end
    acc_last = push;
    @(posedge clk);
    #1;
    check("enable", 64'(wb.enable), 64'(exp_en));
    check("ldr_data", 64'(wb.ldr_data), 64'(exp_data));
    check("fifo_count", 64'(wb.fifo_count), 64'(mq.size()));
`ifdef WB_SCOREBOARD_EN
    check("pending", 64'(wb.pending), 64'(model_pending()));
`endif
  endtask

  task automatic idle_inputs();
    wb.alu_we   = 0;
    wb.alu_addr = '0;
    wb.alu_data = '0;
    wb.ld_valid = 0;
    wb.ld_addr  = '0;
    wb.ld_data  = '0;
  endtask

  initial begin
    int n;
    int t;
    reset = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    check("rst_enable", 64'(wb.enable), 64'h0);
    check("rst_count", 64'(wb.fifo_count), 64'h0);
    reset = 0;
    cycle();

    // 1: single ALU write
    wb.alu_we = 1; wb.alu_addr = 4'd5; wb.alu_data = 32'hDEADBEEF;
    cycle();
    check("t1_enable", 64'(wb.enable), 64'h0020);
    check("t1_data", 64'(wb.ldr_data), 64'hDEADBEEF);
    wb.alu_we = 0;
    cycle();
    check("t1_enable_off", 64'(wb.enable), 64'h0);
    check("t1_data_hold", 64'(wb.ldr_data), 64'hDEADBEEF);

    // 2: single load into an idle FIFO
    wb.ld_valid = 1; wb.ld_addr = 4'd3; wb.ld_data = 32'h11;
    cycle();
    check("t2_accept", 64'(acc_last), 64'h1);
    wb.ld_valid = 0;
    check("t2_enable_early", 64'(wb.enable), 64'h0);
    cycle();
    check("t2_enable", 64'(wb.enable), 64'h0008);
    check("t2_data", 64'(wb.ldr_data), 64'h11);
    check("t2_count", 64'(wb.fifo_count), 64'h0);
    cycle();

    // 3: ALU priority over a queued load
    wb.ld_valid = 1; wb.ld_addr = 4'd1; wb.ld_data = 32'h1111;
    cycle();
    wb.ld_valid = 0;
    wb.alu_we = 1;
    for (int i = 0; i < 3; i++) begin
      wb.alu_addr = AW'(2 + 2 * i);
      wb.alu_data = 32'h100 + 32'(i);
      cycle();
      check("t3_alu_enable", 64'(wb.enable), 64'(NREG'(1) << (2 + 2 * i)));
      check("t3_count", 64'(wb.fifo_count), 64'h1);
    end
    wb.alu_we = 0;
    cycle();
    check("t3_load_enable", 64'(wb.enable), 64'h0002);
    check("t3_load_data", 64'(wb.ldr_data), 64'h1111);

    // 4: full FIFO with ALU hogging the port
    wb.alu_we = 1; wb.alu_addr = 4'd0; wb.alu_data = 32'hC0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      wb.ld_valid = (n < 5);
      wb.ld_addr  = AW'(8 + n);
      wb.ld_data  = 32'd100 + 32'(n);
      cycle();
      if (acc_last) n++;
    end
    check("t4_accepted", 64'(n), 64'd4);
    check("t4_count_full", 64'(wb.fifo_count), 64'd4);
    check("t4_ready_low", 64'(wb.ld_ready), 64'h0);
    wb.alu_we = 0;
    wb.ld_addr = AW'(8 + n);
    wb.ld_data = 32'd100 + 32'(n);
    t = 0;
    while (((n < 5) || (mq.size() != 0)) && (t < 12)) begin
      cycle();
      if (acc_last) begin
        n++;
        wb.ld_valid = 0;
      end
      t++;
    end
    check("t4_drained", 64'(t < 12), 64'h1);
    check("t4_last_enable", 64'(wb.enable), 64'h1000);
    cycle();

    // 5: kill a queued load
    wb.ld_valid = 1; wb.ld_addr = 4'd7; wb.ld_data = 32'h77;
    cycle();
`ifdef WB_SCOREBOARD_EN
    check("t5_pending_set", 64'(wb.pending[7]), 64'h1);
`endif
    wb.ld_valid = 0;
    wb.alu_we = 1; wb.alu_addr = 4'd7; wb.alu_data = 32'hA5;
    cycle();
    check("t5_alu_enable", 64'(wb.enable), 64'h0080);
    check("t5_alu_data", 64'(wb.ldr_data), 64'hA5);
`ifdef WB_SCOREBOARD_EN
    check("t5_pending_clr", 64'(wb.pending[7]), 64'h0);
`endif
    wb.alu_we = 0;
    cycle();
    check("t5_bubble", 64'(wb.enable), 64'h0);
    check("t5_data_hold", 64'(wb.ldr_data), 64'hA5);
    check("t5_count", 64'(wb.fifo_count), 64'h0);

    // 6: reset with three loads queued
    wb.alu_we = 1; wb.alu_addr = 4'd0; wb.alu_data = 32'hE0;
    for (int i = 0; i < 3; i++) begin
      wb.ld_valid = 1; wb.ld_addr = AW'(9 + i); wb.ld_data = 32'h900 + 32'(i);
      cycle();
    end
    check("t6_count_pre", 64'(wb.fifo_count), 64'd3);
    idle_inputs();
    reset = 1;
    cycle();
    check("t6_enable", 64'(wb.enable), 64'h0);
    check("t6_count", 64'(wb.fifo_count), 64'h0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_no_write", 64'(wb.enable), 64'h0);
    end

    // Randomized traffic over a small register window to provoke kills
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      wb.alu_we   = ($urandom_range(0, 1) == 1);
      wb.alu_addr = AW'($urandom_range(0, 3));
      wb.alu_data = $urandom;
      if (!wb.ld_valid || acc_last) begin
        wb.ld_valid = ($urandom_range(0, 2) != 0);
        wb.ld_addr  = AW'($urandom_range(0, 3));
        wb.ld_data  = $urandom;
      end
      cycle();
    end
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();
    check("final_empty", 64'(wb.fifo_count), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
